// File: rtl/levenshtein_pkg.sv
`default_nettype none
// ============================================================================
// Module      : levenshtein_pkg
// Description : Shared states, register map and dictionary byte codes for the
//               Levenshtein dictionary search core.
// Revision    : 1.0  initial release
// ============================================================================
package levenshtein_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ_DICT = 3'd1,
        ST_READ_VEC  = 3'd2,
        ST_CALC      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [2:0] c_reg_ctrl        = 3'd0;
    localparam logic [2:0] c_reg_word_len    = 3'd1;
    localparam logic [2:0] c_reg_distance    = 3'd2;
    localparam logic [2:0] c_reg_idx_hi      = 3'd3;
    localparam logic [2:0] c_reg_idx_lo      = 3'd4;
    localparam logic [2:0] c_reg_threshold   = 3'd5;
    localparam logic [2:0] c_reg_match_count = 3'd6;

    localparam logic [7:0] WORD_TERMINATOR = 8'h00;
    localparam logic [7:0] DICT_TERMINATOR = 8'h01;

endpackage : levenshtein_pkg
`default_nettype wire

// File: rtl/levenshtein_step.sv
`default_nettype none
// ============================================================================
// Module      : levenshtein_step
// Description : One Myers bit-parallel column update for a single text char;
//               produces next VP/VN and the score increment/decrement flags.
// Revision    : 1.0  initial release
// ============================================================================
module levenshtein_step #(
    parameter int BITVECTOR_WIDTH = 32
) (
    input  logic [BITVECTOR_WIDTH-1:0] i_pm,
    input  logic [BITVECTOR_WIDTH-1:0] i_vp,
    input  logic [BITVECTOR_WIDTH-1:0] i_vn,
    input  logic [BITVECTOR_WIDTH-1:0] i_mask,
    output logic [BITVECTOR_WIDTH-1:0] o_vp,
    output logic [BITVECTOR_WIDTH-1:0] o_vn,
    output logic                       o_inc,
    output logic                       o_dec
);

    logic [BITVECTOR_WIDTH-1:0] w_d0;
    logic [BITVECTOR_WIDTH-1:0] w_hp;
    logic [BITVECTOR_WIDTH-1:0] w_hn;
    logic [BITVECTOR_WIDTH-1:0] w_hp_sh;

    assign w_d0    = (((i_pm & i_vp) + i_vp) ^ i_vp) | i_pm | i_vn;
    assign w_hp    = i_vn | ~(w_d0 | i_vp);
    assign w_hn    = w_d0 & i_vp;
    // Row 0 of the DP matrix always grows by one per text char.
    assign w_hp_sh = (w_hp << 1) | BITVECTOR_WIDTH'(1);

    assign o_inc = |(w_hp & i_mask);
    assign o_dec = |(w_hn & i_mask);
    assign o_vp  = (w_hn << 1) | ~(w_d0 | w_hp_sh);
    assign o_vn  = w_d0 & w_hp_sh;

endmodule : levenshtein_step
`default_nettype wire

// File: rtl/levenshtein_search_core.sv
`default_nettype none
// ============================================================================
// Module      : levenshtein_search_core
// Description : Wishbone-configured Myers Levenshtein dictionary search; the
//               master port streams dictionary bytes and per-char PM vectors.
//               Optional threshold match counter: LEVENSHTEIN_THRESHOLD_EN.
// Revision    : 1.0  initial release
// ============================================================================
module levenshtein_search_core
    import levenshtein_pkg::*;
#(
    parameter int                           MASTER_ADDR_WIDTH = 24,
    parameter int                           SLAVE_ADDR_WIDTH  = 24,
    parameter int                           BITVECTOR_WIDTH   = 32,
    parameter int                           DISTANCE_WIDTH    = 8,
    parameter int                           ID_WIDTH          = 16,
    parameter logic [MASTER_ADDR_WIDTH-1:0] DICT_ADDR         = 'h400
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         wbm_cyc_o,
    output logic                         wbm_stb_o,
    output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic                         wbm_we_o,
    output logic [7:0]                   wbm_dat_o,
    input  logic                         wbm_ack_i,
    input  logic                         wbm_err_i,
    input  logic                         wbm_rty_i,
    input  logic [7:0]                   wbm_dat_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
    input  logic [7:0]                   wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic                         wbs_err_o,
    output logic                         wbs_rty_o,
    output logic [7:0]                   wbs_dat_o,
    output logic [1:0]                   sram_config
);

    localparam int         c_nbytes = BITVECTOR_WIDTH / 8;
    localparam int         c_bidx_w = $clog2(c_nbytes);
    localparam int         c_vadr_w = 1 + 8 + c_bidx_w;
    localparam logic [6:0] c_max_len = 7'(BITVECTOR_WIDTH);

    state_t                        r_state, w_state_next;
    logic                          r_cyc, r_wbs_ack, r_error;
    logic [1:0]                    r_sram_cfg;
    logic [6:0]                    r_word_len, r_len;
    logic [MASTER_ADDR_WIDTH-1:0]  r_dict_addr;
    logic [7:0]                    r_char;
    logic [c_bidx_w-1:0]           r_byte_idx;
    logic [BITVECTOR_WIDTH-1:0]    r_pm, r_vp, r_vn;
    logic [DISTANCE_WIDTH-1:0]     r_d, r_best_d;
    logic [ID_WIDTH-1:0]           r_idx, r_best_idx;

    logic                          w_slv_acc, w_slv_wr, w_busy, w_reading;
    logic                          w_start, w_abort, w_go;
    logic                          w_rd_ok, w_rd_fail, w_last_byte, w_commit;
    logic [6:0]                    w_len_sel;
    logic [BITVECTOR_WIDTH:0]      w_vp_init_wide;
    logic [BITVECTOR_WIDTH-1:0]    w_vp_init, w_mask, w_vp_next, w_vn_next;
    logic                          w_inc, w_dec;
    logic [DISTANCE_WIDTH+7:0]     w_best_d_ext;
    logic [ID_WIDTH+15:0]          w_best_idx_ext;
    logic [7:0]                    w_rd_data;

    assign w_slv_acc = wbs_cyc_i & wbs_stb_i & ~r_wbs_ack;
    assign w_slv_wr  = w_slv_acc & wbs_we_i;
    assign w_busy    = (r_state == ST_READ_DICT) || (r_state == ST_READ_VEC) || (r_state == ST_CALC);
    assign w_reading = (r_state == ST_READ_DICT) || (r_state == ST_READ_VEC);
    assign w_start   = w_slv_wr && (wbs_adr_i[2:0] == c_reg_ctrl) && wbs_dat_i[7];
    assign w_abort   = w_slv_wr && (wbs_adr_i[2:0] == c_reg_ctrl) && !wbs_dat_i[7] && w_busy;
    assign w_go      = !w_start && !w_abort;

    assign w_rd_fail   = r_cyc & (wbm_err_i | wbm_rty_i);
    assign w_rd_ok     = r_cyc & wbm_ack_i & ~(wbm_err_i | wbm_rty_i);
    assign w_last_byte = (r_byte_idx == c_bidx_w'(c_nbytes - 1));
    assign w_commit    = w_go && w_rd_ok && (r_state == ST_READ_DICT) && (wbm_dat_i == WORD_TERMINATOR);

    // Start takes the fresh (clamped) WORD_LEN; word commits reuse the latched length.
    assign w_len_sel      = w_start ? ((r_word_len > c_max_len) ? c_max_len : r_word_len) : r_len;
    assign w_vp_init_wide = ({{BITVECTOR_WIDTH{1'b0}}, 1'b1} << w_len_sel) - (BITVECTOR_WIDTH+1)'(1);
    assign w_vp_init      = w_vp_init_wide[BITVECTOR_WIDTH-1:0];
    assign w_mask         = (r_len == 7'd0) ? '0 : (BITVECTOR_WIDTH'(1) << (r_len - 7'd1));

    levenshtein_step #(
        .BITVECTOR_WIDTH (BITVECTOR_WIDTH)
    ) u_step (
        .i_pm   (r_pm),
        .i_vp   (r_vp),
        .i_vn   (r_vn),
        .i_mask (w_mask),
        .o_vp   (w_vp_next),
        .o_vn   (w_vn_next),
        .o_inc  (w_inc),
        .o_dec  (w_dec)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = ST_READ_DICT;
        end else if (w_abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_READ_DICT: begin
                    if (w_rd_fail) w_state_next = ST_IDLE;
                    else if (w_rd_ok) begin
                        if (wbm_dat_i == DICT_TERMINATOR)      w_state_next = ST_DONE;
                        else if (wbm_dat_i != WORD_TERMINATOR) w_state_next = ST_READ_VEC;
                    end
                end
                ST_READ_VEC: begin
                    if (w_rd_fail)                  w_state_next = ST_IDLE;
                    else if (w_rd_ok && w_last_byte) w_state_next = ST_CALC;
                end
                ST_CALC: w_state_next = ST_READ_DICT;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cyc       <= 1'b0;
            r_wbs_ack   <= 1'b0;
            r_error     <= 1'b0;
            r_sram_cfg  <= 2'b00;
            r_word_len  <= 7'd0;
            r_len       <= 7'd0;
            r_dict_addr <= DICT_ADDR;
            r_char      <= 8'd0;
            r_byte_idx  <= '0;
            r_pm        <= '0;
            r_vp        <= '0;
            r_vn        <= '0;
            r_d         <= '0;
            r_best_d    <= '1;
            r_best_idx  <= '0;
            r_idx       <= '0;
        end else begin
            r_wbs_ack <= w_slv_acc;
            if (w_slv_wr && (wbs_adr_i[2:0] == c_reg_word_len)) r_word_len <= wbs_dat_i[6:0];

            // Each read raises cyc one cycle after entry and drops it on termination.
            if (!w_go || w_rd_ok || w_rd_fail) r_cyc <= 1'b0;
            else if (w_reading && !r_cyc)      r_cyc <= 1'b1;

            if (w_start) begin
                r_sram_cfg  <= wbs_dat_i[6:5];
                r_error     <= 1'b0;
                r_len       <= w_len_sel;
                r_dict_addr <= DICT_ADDR;
                r_idx       <= '0;
                r_best_d    <= '1;
                r_best_idx  <= '0;
                r_d         <= DISTANCE_WIDTH'(w_len_sel);
                r_vp        <= w_vp_init;
                r_vn        <= '0;
                r_byte_idx  <= '0;
            end else if (!w_abort) begin
                if (w_rd_fail) r_error <= 1'b1;
                if (w_rd_ok && (r_state == ST_READ_DICT)) begin
                    r_dict_addr <= r_dict_addr + MASTER_ADDR_WIDTH'(1);
                    r_char      <= wbm_dat_i;
                    r_byte_idx  <= '0;
                end
                if (w_commit) begin
                    if (r_d < r_best_d) begin
                        r_best_d   <= r_d;
                        r_best_idx <= r_idx;
                    end
                    r_idx <= r_idx + ID_WIDTH'(1);
                    r_d   <= DISTANCE_WIDTH'(r_len);
                    r_vp  <= w_vp_init;
                    r_vn  <= '0;
                end
                if (w_rd_ok && (r_state == ST_READ_VEC)) begin
                    r_pm       <= {r_pm[BITVECTOR_WIDTH-9:0], wbm_dat_i};
                    r_byte_idx <= r_byte_idx + c_bidx_w'(1);
                end
                if (r_state == ST_CALC) begin
                    r_vp <= w_vp_next;
                    r_vn <= w_vn_next;
                    if (w_inc)      r_d <= r_d + DISTANCE_WIDTH'(1);
                    else if (w_dec) r_d <= r_d - DISTANCE_WIDTH'(1);
                end
            end
        end
    end

`ifdef LEVENSHTEIN_THRESHOLD_EN
    logic [7:0] r_threshold, r_match_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_threshold <= 8'hFF;
            r_match_cnt <= 8'd0;
        end else begin
            if (w_slv_wr && (wbs_adr_i[2:0] == c_reg_threshold)) r_threshold <= wbs_dat_i;
            if (w_start) r_match_cnt <= 8'd0;
            else if (w_commit && ({8'd0, r_d} <= {{DISTANCE_WIDTH{1'b0}}, r_threshold})
                     && (r_match_cnt != 8'hFF))
                r_match_cnt <= r_match_cnt + 8'd1;
        end
    end
`endif

    assign w_best_d_ext   = {8'd0, r_best_d};
    assign w_best_idx_ext = {16'd0, r_best_idx};

    always_comb begin
        w_rd_data = 8'd0;
        case (wbs_adr_i[2:0])
            c_reg_ctrl:        w_rd_data = {w_busy, r_sram_cfg, r_error, 4'b0000};
            c_reg_word_len:    w_rd_data = {1'b0, r_word_len};
            c_reg_distance:    w_rd_data = w_best_d_ext[7:0];
            c_reg_idx_hi:      w_rd_data = w_best_idx_ext[15:8];
            c_reg_idx_lo:      w_rd_data = w_best_idx_ext[7:0];
`ifdef LEVENSHTEIN_THRESHOLD_EN
            c_reg_threshold:   w_rd_data = r_threshold;
            c_reg_match_count: w_rd_data = r_match_cnt;
`endif
            default:           w_rd_data = 8'd0;
        endcase
    end

    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = 1'b0;
    assign wbm_dat_o   = 8'd0;
    assign wbm_adr_o   = (r_state == ST_READ_VEC)
                       ? MASTER_ADDR_WIDTH'(c_vadr_w'({1'b1, r_char, r_byte_idx}))
                       : r_dict_addr;
    assign wbs_ack_o   = r_wbs_ack;
    assign wbs_err_o   = 1'b0;
    assign wbs_rty_o   = 1'b0;
    assign wbs_dat_o   = w_rd_data;
    assign sram_config = r_sram_cfg;

    logic w_unused;
    assign w_unused = &{1'b0, wbs_adr_i, w_vp_init_wide[BITVECTOR_WIDTH],
                        w_best_d_ext, w_best_idx_ext, 1'b0};

endmodule : levenshtein_search_core
`default_nettype wire
